// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128 key schedule, emits round keys 0..10 one per clock after start.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start, key       begin expansion of key (sampled only while idle)
//   busy, rk_valid   high while round keys are being emitted
//   rk_round, rk     current round index and round key {w4r..w4r+3}
//   done             one-cycle pulse with round 10

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    localparam logic [0:255][7:0] lut = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign s = lut[a];
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [127:0] w, w_n;
    logic [31:0] rot, sub, t, n0, n1, n2, n3;
    logic [7:0] rcon;

    assign rot = {w[23:0], w[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
    end

    // rcon for the round being produced, i.e. indexed by cnt+1
    always_comb begin
        rcon = cnt == 4'd0 ? 8'h01 :
               cnt == 4'd1 ? 8'h02 :
               cnt == 4'd2 ? 8'h04 :
               cnt == 4'd3 ? 8'h08 :
               cnt == 4'd4 ? 8'h10 :
               cnt == 4'd5 ? 8'h20 :
               cnt == 4'd6 ? 8'h40 :
               cnt == 4'd7 ? 8'h80 :
               cnt == 4'd8 ? 8'h1b :
               cnt == 4'd9 ? 8'h36 : 8'h00;
    end

    assign t  = sub ^ {rcon, 24'h0};
    assign n0 = w[127:96] ^ t;
    assign n1 = w[95:64]  ^ n0;
    assign n2 = w[63:32]  ^ n1;
    assign n3 = w[31:0]   ^ n2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            w     <= 128'h0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            w     <= w_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        w_n     = w;
        if (state == IDLE) begin
            if (start) begin
                state_n = EMIT;
                cnt_n   = 4'd0;
                w_n     = key;
            end
        end else if (cnt == 4'd10) begin
            state_n = IDLE;
        end else begin
            cnt_n = cnt + 4'd1;
            w_n   = {n0, n1, n2, n3};
        end
    end

    assign busy     = state == EMIT;
    assign rk_valid = busy;
    assign rk_round = cnt;
    assign rk       = w;
    assign done     = busy && cnt == 4'd10;
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: self-checking bench for aes_key_expand against a FIPS-197 reference model.
module tb_aes_key_expand;
    logic clk = 0, rst = 1, start = 0;
    logic [127:0] key = '0;
    logic busy, rk_valid, done;
    logic [3:0] rk_round;
    logic [127:0] rk;

    aes_key_expand dut (
        .clk(clk), .rst(rst), .start(start), .key(key),
        .busy(busy), .rk_valid(rk_valid), .rk_round(rk_round), .rk(rk), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;

    localparam logic [127:0] KA1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KONE = {128{1'b1}};

    typedef struct {
        logic [127:0] k;
        int           r;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [7];

    logic [7:0]   sb [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] cap_rk [0:10];
    logic [3:0]   cap_round [0:10];
    logic         cap_done [0:10];
    logic         cap_act [0:10];
    logic         busy_after;

    task automatic chk(input string name, input int r, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s r=%0d got %h want %h", name, r, act, exp);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h0;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] wm [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) wm[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wm[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            wm[i] = wm[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
    endtask

    // Starts a run in the current cycle; mask[r] drives start during the cycle of round r,
    // and key switches to kpost right after the start cycle.
    task automatic run(input logic [127:0] k, input logic [127:0] kpost, input logic [11:0] mask);
        key = k;
        start = 1;
        for (int r = 0; r <= 10; r++) begin
            @(negedge clk);
            cap_rk[r]    = rk;
            cap_round[r] = rk_round;
            cap_done[r]  = done;
            cap_act[r]   = busy & rk_valid;
            start = mask[r];
            if (r == 0) key = kpost;
        end
        @(negedge clk);
        busy_after = busy | rk_valid | done;
        start = 0;
    endtask

    task automatic check_model(input logic [127:0] k, input string tag);
        expand(k);
        for (int r = 0; r <= 10; r++) begin
            chk({tag, "_rk"}, r, cap_rk[r], exp_rk[r]);
            chk({tag, "_round"}, r, 128'(cap_round[r]), 128'(r));
            chk({tag, "_done"}, r, 128'(cap_done[r]), 128'(r == 10));
            chk({tag, "_active"}, r, 128'(cap_act[r]), 128'(1));
        end
        chk({tag, "_idle_after"}, 11, 128'(busy_after), 128'(0));
    endtask

    initial begin
        logic seen;
        logic [127:0] k;
        build_sbox();
        vecs[0] = '{KA1, 0, KA1};
        vecs[1] = '{KA1, 1, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{KA1, 2, 128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3] = '{KA1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4] = '{128'h0, 1, 128'h62636363626363636263636362636363};
        vecs[5] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[6] = '{KONE, 1, 128'he8e9e9e917161616e8e9e9e917161616};

        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", 0, 128'(busy), 128'(0));
        chk("reset_valid", 0, 128'(rk_valid), 128'(0));
        chk("reset_round", 0, 128'(rk_round), 128'(0));
        chk("reset_rk", 0, rk, 128'h0);
        chk("reset_done", 0, 128'(done), 128'(0));
        rst = 0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run(vecs[i].k, vecs[i].k, 12'h0);
            chk("fips_vec", vecs[i].r, cap_rk[vecs[i].r], vecs[i].exp);
            check_model(vecs[i].k, "vec_run");
        end

        run(KA1, KA1, 12'h410);
        check_model(KA1, "ignored_start");
        @(negedge clk);
        chk("ignored_start_stays_idle", 12, 128'(busy), 128'(0));

        key = KA1;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("midrst_at_round", 4, 128'(rk_round), 128'(4));
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_busy", 0, 128'(busy), 128'(0));
        chk("midrst_valid", 0, 128'(rk_valid), 128'(0));
        chk("midrst_round", 0, 128'(rk_round), 128'(0));
        chk("midrst_rk", 0, rk, 128'h0);
        chk("midrst_done", 0, 128'(done), 128'(0));
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen |= done | busy;
        end
        chk("midrst_no_done", 0, 128'(seen), 128'(0));
        run(KA1, KA1, 12'h0);
        check_model(KA1, "after_midrst");

        run(KA1, KONE, 12'h0);
        check_model(KA1, "key_stable");
        run(KONE, KONE, 12'h0);
        check_model(KONE, "second_run");
        chk("second_run_r1", 1, cap_rk[1], 128'he8e9e9e917161616e8e9e9e917161616);

        rst = 1;
        start = 1;
        key = KA1;
        @(negedge clk);
        rst = 0;
        start = 0;
        chk("rst_beats_start", 0, 128'(busy), 128'(0));
        @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run(k, k, 12'h0);
            check_model(k, "random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Sequential AES-128 key-expansion engine that produces the eleven round keys from a 128-bit cipher key, one round key per clock. It sits directly upstream of the round datapath and key-schedule consumers. Internally it applies the one-byte word rotation (RotWord), SubWord through four S-box instances, and the Rcon injection that the round-key recurrence needs.

## Interface
Parameters: none (fixed AES-128: Nk=4, Nr=10).

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request expansion of `key`; sampled only while idle
- key  in  128  cipher key; byte 0 = key[127:120]; word w0 = key[127:96]
- busy  out  1  high while round keys are being emitted
- rk_valid  out  1  `rk`/`rk_round` hold a valid round key this cycle
- rk_round  out  4  round index 0..10 of `rk`
- rk  out  128  round key {w4r, w4r+1, w4r+2, w4r+3}, same byte order as `key`
- done  out  1  one-cycle pulse coinciding with round 10

## Operation
- FSM states:
  - IDLE: on `start`=1, latch `key` into the working register, clear the round counter, go to EMIT.
  - EMIT: present the working register as `rk` with `rk_valid`=1 and `rk_round`=counter.
    - If counter < 10: load the next key, increment the counter, stay in EMIT.
    - If counter = 10: assert `done`, go to IDLE.
- Next-key recurrence, with working words w0..w3 (w0 most significant):
  - rot = {w3[23:0], w3[31:24]} (rotate left by one byte)
  - t = SubWord(rot) ^ {rcon, 24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2
- rcon is indexed by the round being produced (1..10): 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. The table is combinational and indexed by counter+1; there is no GF doubling register.
- SubWord applies the FIPS-197 S-box to each of the four bytes. Four parallel combinational 256-entry lookups.
- `start` is ignored while `busy`=1; there is no queueing and no restart.
- `key` is sampled only in the start cycle; later changes have no effect on the current run.
- `rk` holds its last value after the run; it is meaningful only when `rk_valid`=1.

## Timing
- Reset values: `busy`=0, `rk_valid`=0, `rk_round`=0, `rk`=0, `done`=0; FSM in IDLE; counter 0.
- `rst` has priority over everything. Reset mid-run aborts immediately: the next cycle shows all outputs at reset values, and no `done` is produced.
- With `start` sampled high at edge T:
  - round r appears on the outputs during cycle T+1+r, for r = 0..10.
  - `busy` and `rk_valid` are high continuously for cycles T+1..T+11 (11 cycles).
  - `done` is high only in cycle T+11.
- Back-to-back runs:
  - `start` high in cycle T+11 is ignored, because `busy`=1.
  - `start` high in cycle T+12 begins a new run whose round 0 appears in T+13.
  - Minimum run-to-run spacing is 12 cycles.
- Simultaneous `rst` and `start` in the same cycle: reset wins and the run is not started.
- Critical path: one S-box plus a 4-deep XOR chain plus the register. No multicycle paths.

## Test plan
- FIPS-197 A.1 vector: key 2b7e151628aed2a6abf7158809cf4f3c -> required rounds:
  - round 0 = key
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 2 = f2c295f27a96b9435935807a7359f67f
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `done`=1 in that same cycle only
- All-zero key -> required rounds:
  - round 1 = 62636363626363636263636362636363
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e
  - `rk_round` steps 0..10 with no gaps
- Cycle accounting: pulse `start` at edge T -> `busy`/`rk_valid` high exactly in T+1..T+11 and low at T+12. Also pulse `start` again at T+5 and at T+11 -> both are ignored, and the outputs match the first run exactly.
- Mid-run reset: assert `rst` for one cycle during round 4 -> next cycle all outputs are 0 and no `done` appears. Then `start` with the A.1 key -> full, correct 11-key sequence.
- Key stability: change `key` to all-ones the cycle after `start` -> the emitted rounds still match the originally sampled key. A second run is then started at T+12 with the new key -> its round 1 = e8e9e9e917161616e8e9e9e917161616.
- Random regression: 200 random keys checked against a reference model. Every round key, `rk_round`, and the position of the `done` pulse must match.
